mpi_tx_rendezvous_ctrl: RTL and testbench

- Send-side MPI rendezvous sequencer between a kernel payload stream and the 64-bit Ethernet TX AXI-Stream.
- Per accepted request it runs the full exchange:
  - emit Ethernet header + SYNC_ENV envelope;
  - wait for a matching CLR2SND on the RX stream;
  - emit Ethernet header + DATA header + payload;
  - wait for DATA_TRANSMISSION_DONE, then report completion.

---
 rtl/mpi_tx_rendezvous_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mpi_tx_rendezvous_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_tx_rendezvous_ctrl.sv
// Send-side MPI rendezvous sequencer: SYNC_ENV -> CLR2SND -> DATA -> DONE.
// Optional wait-state timeout enabled by defining MPI_TX_TIMEOUT_EN.
module mpi_tx_rendezvous_ctrl #(
    parameter logic [47:0] FPGA_MAC                 = 48'hfa163e55ca02,
    parameter logic [7:0]  C_SYNC_ENV_PACKET        = 8'd1,
    parameter logic [7:0]  C_CLR2SND_PACKET         = 8'd2,
    parameter logic [7:0]  C_DATA_PACKET            = 8'd3,
    parameter logic [7:0]  C_DATA_TRANSMISSION_DONE = 8'd4
`ifdef MPI_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES           = 1000000
`endif
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_dst_mac,
    input  logic [15:0] req_dst_rank,
    input  logic [7:0]  req_src_rank,
    input  logic [15:0] req_size,
    input  logic [7:0]  req_tag,
    input  logic [63:0] s_data_DATA,
    input  logic [7:0]  s_data_KEEP,
    input  logic        s_data_LAST,
    input  logic        s_data_VALID,
    output logic        s_data_READY,
    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    output logic        done,
    output logic        busy,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, E_ETH0, E_ETH1, E_HDR, E_PAD, W_CTS,
        D_ETH0, D_ETH1, D_HDR, D_PAY, W_DONE
    } state_t;

    state_t      state;
    logic        rdy_q, busy_q, done_q, err_q;
    logic [47:0] mac_q;
    logic [15:0] drank_q;
    logic [7:0]  srank_q;
    logic [15:0] size_q;
    logic [7:0]  tag_q;
    logic [15:0] beats_q;
    logic [15:0] rem_q;
    logic [1:0]  rx_idx;
    logic        rx_mac_ok;

    function automatic logic [63:0] rev64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction

    logic [63:0] eth0, eth1, hdr_env, hdr_dat, rx_rev;
    logic [15:0] len_dat;
    logic [7:0]  keep_fin, exp_type;
    logic        last_pay, tx_fire, in_w, hit, unused_ok;

    assign eth0     = rev64({mac_q, FPGA_MAC[47:32]});
    assign eth1     = rev64({FPGA_MAC[31:0], 16'h7400, drank_q[7:0], 8'h00});
    assign len_dat  = {size_q[13:0], 2'b00};
    assign hdr_env  = {8'd1, tag_q, size_q, C_SYNC_ENV_PACKET, srank_q, drank_q};
    assign hdr_dat  = {8'd1, tag_q, len_dat, C_DATA_PACKET, srank_q, drank_q};
    assign last_pay = (rem_q == 16'd1);
    assign keep_fin = size_q[0] ? 8'h0f : 8'hff;
    assign tx_fire  = stream_out_VALID && stream_out_READY;

    // RX sniffer: beat0 carries our MAC, beat2 the MPI header
    assign rx_rev   = rev64(stream_in_DATA);
    assign in_w     = (state == W_CTS) || (state == W_DONE);
    assign exp_type = (state == W_DONE) ? C_DATA_TRANSMISSION_DONE
                                        : C_CLR2SND_PACKET;
    assign hit = stream_in_VALID && in_w && (rx_idx == 2'd2) && rx_mac_ok
              && (stream_in_DATA[31:24] == exp_type)
              && (stream_in_DATA[23:16] == drank_q[7:0])
              && (stream_in_DATA[15:0] == {8'h00, srank_q});

    assign stream_in_READY = 1'b1;
    assign req_ready       = rdy_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = err_q;
    assign unused_ok       = ^{stream_in_KEEP, rx_rev[15:0]};

    always_comb begin
        stream_out_DATA  = '0;
        stream_out_KEEP  = '0;
        stream_out_LAST  = 1'b0;
        stream_out_VALID = 1'b0;
        s_data_READY     = 1'b0;
        unique case (state)
            E_ETH0, D_ETH0: begin
                stream_out_VALID = 1'b1;
                stream_out_DATA  = eth0;
                stream_out_KEEP  = 8'hff;
            end
            E_ETH1, D_ETH1: begin
                stream_out_VALID = 1'b1;
                stream_out_DATA  = eth1;
                stream_out_KEEP  = 8'hff;
            end
            E_HDR: begin
                stream_out_VALID = 1'b1;
                stream_out_DATA  = hdr_env;
                stream_out_KEEP  = 8'hff;
            end
            E_PAD: begin
                stream_out_VALID = 1'b1;
                stream_out_KEEP  = 8'hff;
                stream_out_LAST  = 1'b1;
            end
            D_HDR: begin
                stream_out_VALID = 1'b1;
                stream_out_DATA  = hdr_dat;
                stream_out_KEEP  = 8'hff;
                stream_out_LAST  = (beats_q == 16'd0);
            end
            D_PAY: begin
                stream_out_VALID = s_data_VALID;
                s_data_READY     = stream_out_READY;
                stream_out_DATA  = s_data_DATA;
                stream_out_LAST  = last_pay;
                stream_out_KEEP  = last_pay ? (s_data_KEEP & keep_fin)
                                            : s_data_KEEP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_idx    <= 2'd0;
            rx_mac_ok <= 1'b0;
        end else if (stream_in_VALID) begin
            if (rx_idx == 2'd0)
                rx_mac_ok <= (rx_rev[63:16] == FPGA_MAC);
            if (stream_in_LAST)
                rx_idx <= 2'd0;
            else if (rx_idx != 2'd3)
                rx_idx <= rx_idx + 2'd1;
        end
    end

`ifdef MPI_TX_TIMEOUT_EN
    logic [31:0] tmo_q;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mac_q   <= '0;
            drank_q <= '0;
            srank_q <= '0;
            size_q  <= '0;
            tag_q   <= '0;
            beats_q <= '0;
            rem_q   <= '0;
`ifdef MPI_TX_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (req_valid && rdy_q) begin
                        mac_q   <= req_dst_mac;
                        drank_q <= req_dst_rank;
                        srank_q <= req_src_rank;
                        size_q  <= req_size;
                        tag_q   <= req_tag;
                        beats_q <= {1'b0, req_size[15:1]}
                                 + {15'd0, req_size[0]};
                        err_q   <= 1'b0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= E_ETH0;
                    end
                end
                E_ETH0: if (tx_fire) state <= E_ETH1;
                E_ETH1: if (tx_fire) state <= E_HDR;
                E_HDR:  if (tx_fire) state <= E_PAD;
                E_PAD:  if (tx_fire) state <= W_CTS;
                W_CTS:  if (hit) state <= D_ETH0;
                D_ETH0: if (tx_fire) state <= D_ETH1;
                D_ETH1: if (tx_fire) state <= D_HDR;
                D_HDR: if (tx_fire) begin
                    rem_q <= beats_q;
                    state <= (beats_q == 16'd0) ? W_DONE : D_PAY;
                end
                // kernel LAST must coincide with our final beat
                D_PAY: if (tx_fire) begin
                    if (s_data_LAST != last_pay) err_q <= 1'b1;
                    if (last_pay) state <= W_DONE;
                    else rem_q <= rem_q - 16'd1;
                end
                W_DONE: if (hit) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
`ifdef MPI_TX_TIMEOUT_EN
            if (in_w && !hit) begin
                if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_q  <= 1'b1;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b1;
                    tmo_q  <= '0;
                end else begin
                    tmo_q <= tmo_q + 32'd1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mpi_tx_rendezvous_ctrl.sv
// Directed bench for mpi_tx_rendezvous_ctrl.
// Hand-computed frames, RX injection, backpressure, reset mid-payload.
module tb_mpi_tx_rendezvous_ctrl;

    localparam logic [47:0] FMAC  = 48'hfa163e55ca02;
    localparam logic [47:0] MAC_A = 48'h0a0b0c0d0e0f;
    localparam logic [47:0] MAC_B = 48'h112233445566;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_dst_mac = '0;
    logic [15:0] req_dst_rank = '0;
    logic [7:0]  req_src_rank = '0;
    logic [15:0] req_size = '0;
    logic [7:0]  req_tag = '0;
    logic [63:0] s_data_DATA = '0;
    logic [7:0]  s_data_KEEP = 8'hff;
    logic        s_data_LAST = 1'b0;
    logic        s_data_VALID = 1'b0;
    logic        s_data_READY;
    logic [63:0] stream_out_DATA;
    logic [7:0]  stream_out_KEEP;
    logic        stream_out_LAST;
    logic        stream_out_VALID;
    logic        stream_out_READY = 1'b1;
    logic [63:0] stream_in_DATA = '0;
    logic [7:0]  stream_in_KEEP = 8'hff;
    logic        stream_in_LAST = 1'b0;
    logic        stream_in_VALID = 1'b0;
    logic        stream_in_READY;
    logic        done, busy, error;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    mpi_tx_rendezvous_ctrl dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_mac(req_dst_mac), .req_dst_rank(req_dst_rank),
        .req_src_rank(req_src_rank), .req_size(req_size),
        .req_tag(req_tag),
        .s_data_DATA(s_data_DATA), .s_data_KEEP(s_data_KEEP),
        .s_data_LAST(s_data_LAST), .s_data_VALID(s_data_VALID),
        .s_data_READY(s_data_READY),
        .stream_out_DATA(stream_out_DATA),
        .stream_out_KEEP(stream_out_KEEP),
        .stream_out_LAST(stream_out_LAST),
        .stream_out_VALID(stream_out_VALID),
        .stream_out_READY(stream_out_READY),
        .stream_in_DATA(stream_in_DATA),
        .stream_in_KEEP(stream_in_KEEP),
        .stream_in_LAST(stream_in_LAST),
        .stream_in_VALID(stream_in_VALID),
        .stream_in_READY(stream_in_READY),
        .done(done), .busy(busy), .error(error)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction

    // Entered and left at posedge+1
    task automatic expect_beat(input string tag, input logic [63:0] d,
                               input logic [7:0] k, input logic l,
                               input bit bp);
        bit got = 1'b0;
        bit held = 1'b0;
        logic [63:0] hd = '0;
        logic [7:0] hk = '0;
        logic hl = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            stream_out_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stream_out_VALID) begin
                if (held) begin
                    chk({tag, "_hold_d"}, stream_out_DATA, hd);
                    chk({tag, "_hold_k"}, {56'd0, stream_out_KEEP},
                        {56'd0, hk});
                    chk({tag, "_hold_l"}, {63'd0, stream_out_LAST},
                        {63'd0, hl});
                end
                if (stream_out_READY) begin
                    got = 1'b1;
                end else begin
                    held = 1'b1;
                    hd = stream_out_DATA;
                    hk = stream_out_KEEP;
                    hl = stream_out_LAST;
                end
            end
            if (!got) begin
                @(posedge aclk);
                #1;
            end
        end
        chk({tag, "_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            chk({tag, "_data"}, stream_out_DATA, d);
            chk({tag, "_keep"}, {56'd0, stream_out_KEEP}, {56'd0, k});
            chk({tag, "_last"}, {63'd0, stream_out_LAST}, {63'd0, l});
        end
        @(posedge aclk);
        #1;
        stream_out_READY = 1'b1;
    endtask

    task automatic send_req(input logic [47:0] mac, input logic [15:0] dr,
                            input logic [7:0] sr, input logic [15:0] sz,
                            input logic [7:0] tg);
        bit rdy = 1'b0;
        req_dst_mac = mac;
        req_dst_rank = dr;
        req_src_rank = sr;
        req_size = sz;
        req_tag = tg;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !rdy; i++) begin
            if (req_ready) rdy = 1'b1;
            else begin
                @(posedge aclk);
                #1;
            end
        end
        chk("req_ready_wait", {63'd0, rdy}, 64'd1);
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // n beats of a frame addressed to dmac; beat2 = MPI header fields
    task automatic rx_frame(input logic [47:0] dmac, input logic [7:0] typ,
                            input logic [7:0] peer, input logic [15:0] me,
                            input int n);
        logic [63:0] b [3];
        b[0] = rev64({dmac, 16'h1234});
        b[1] = 64'h0000_0000_5555_0000;
        b[2] = {32'h0100_0000, typ, peer, me};
        for (int i = 0; i < n; i++) begin
            stream_in_VALID = 1'b1;
            stream_in_DATA = b[i];
            stream_in_LAST = (i == n - 1);
            @(posedge aclk);
            #1;
        end
        stream_in_VALID = 1'b0;
        stream_in_LAST = 1'b0;
    endtask

    task automatic no_tx(input string tag);
        chk(tag, {63'd0, stream_out_VALID}, 64'd0);
    endtask

    initial begin
        // ---- reset values
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, stream_out_VALID}, 64'd0);
        chk("rst_s_ready", {63'd0, s_data_READY}, 64'd0);
        chk("rst_in_ready", {63'd0, stream_in_READY}, 64'd1);
        chk("rst_flags", {61'd0, done, busy, error}, 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // ---- basic exchange, size=2
        send_req(MAC_A, 16'd0, 8'd1, 16'd2, 8'h5a);
        expect_beat("t1_eth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t1_eth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t1_env", 64'h015a000201010000, 8'hff, 1'b0, 0);
        expect_beat("t1_pad", 64'h0, 8'hff, 1'b1, 0);
        repeat (2) @(posedge aclk);
        #1;
        no_tx("t1_wcts_idle");
        chk("t1_wcts_sready", {63'd0, s_data_READY}, 64'd0);
        rx_frame(FMAC, 8'd2, 8'h00, 16'h0001, 3);
        s_data_VALID = 1'b1;
        s_data_DATA = 64'h1111_2222_3333_4444;
        s_data_LAST = 1'b1;
        expect_beat("t1_deth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t1_deth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t1_dhdr", 64'h015a000803010000, 8'hff, 1'b0, 0);
        expect_beat("t1_pay", 64'h1111_2222_3333_4444, 8'hff, 1'b1, 0);
        s_data_VALID = 1'b0;
        s_data_LAST = 1'b0;
        chk("t1_err", {63'd0, error}, 64'd0);
        no_tx("t1_wdone_idle");
        rx_frame(FMAC, 8'd4, 8'h00, 16'h0001, 3);
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_busy_off", {63'd0, busy}, 64'd0);
        @(posedge aclk);
        #1;
        chk("t1_done_pulse", {63'd0, done}, 64'd0);

        // ---- size=21, RX filtering, 50% backpressure
        send_req(MAC_B, 16'h0203, 8'd5, 16'd21, 8'h07);
        expect_beat("t2_eth0", 64'h16fa665544332211, 8'hff, 1'b0, 1);
        expect_beat("t2_eth1", 64'h0003007402ca553e, 8'hff, 1'b0, 1);
        expect_beat("t2_env", 64'h0107001501050203, 8'hff, 1'b0, 1);
        expect_beat("t2_pad", 64'h0, 8'hff, 1'b1, 1);
        rx_frame(FMAC, 8'd2, 8'h03, 16'h0006, 3);
        no_tx("t2_bad_src");
        rx_frame(FMAC, 8'd4, 8'h03, 16'h0005, 3);
        no_tx("t2_done_type");
        rx_frame(MAC_A, 8'd2, 8'h03, 16'h0005, 3);
        no_tx("t2_bad_mac");
        rx_frame(FMAC, 8'd2, 8'h03, 16'h0005, 2);
        no_tx("t2_short");
        rx_frame(FMAC, 8'd2, 8'h03, 16'h0005, 3);
        expect_beat("t2_deth0", 64'h16fa665544332211, 8'hff, 1'b0, 1);
        expect_beat("t2_deth1", 64'h0003007402ca553e, 8'hff, 1'b0, 1);
        expect_beat("t2_dhdr", 64'h0107005403050203, 8'hff, 1'b0, 1);
        for (int i = 1; i <= 11; i++) begin
            s_data_VALID = 1'b1;
            s_data_DATA = 64'hA000_0000_0000_0000 | 64'(i);
            s_data_LAST = 1'b0;
            expect_beat($sformatf("t2_pay%0d", i), s_data_DATA,
                        (i == 11) ? 8'h0f : 8'hff, i == 11, 1);
        end
        s_data_DATA = 64'hA000_0000_0000_000c;
        chk("t2_err", {63'd0, error}, 64'd1);
        repeat (3) begin
            chk("t2_no_consume", {63'd0, s_data_READY}, 64'd0);
            no_tx("t2_no_tx_wdone");
            @(posedge aclk);
            #1;
        end
        rx_frame(FMAC, 8'd4, 8'h03, 16'h0005, 3);
        chk("t2_done", {63'd0, done}, 64'd1);
        chk("t2_err_sticky", {63'd0, error}, 64'd1);

        // ---- size=0
        send_req(MAC_A, 16'h0009, 8'd2, 16'd0, 8'h33);
        chk("t3_err_clr", {63'd0, error}, 64'd0);
        expect_beat("t3_eth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t3_eth1", 64'h0009007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t3_env", 64'h0133000001020009, 8'hff, 1'b0, 0);
        expect_beat("t3_pad", 64'h0, 8'hff, 1'b1, 0);
        rx_frame(FMAC, 8'd2, 8'h09, 16'h0002, 3);
        expect_beat("t3_deth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t3_deth1", 64'h0009007402ca553e, 8'hff, 1'b0, 0);
        chk("t3_sready_hdr", {63'd0, s_data_READY}, 64'd0);
        expect_beat("t3_dhdr", 64'h0133000003020009, 8'hff, 1'b1, 0);
        chk("t3_sready_wdone", {63'd0, s_data_READY}, 64'd0);
        no_tx("t3_no_payload");
        rx_frame(FMAC, 8'd4, 8'h09, 16'h0002, 3);
        chk("t3_done", {63'd0, done}, 64'd1);
        s_data_VALID = 1'b0;

        // ---- reset during D_PAY
        send_req(MAC_A, 16'd0, 8'd1, 16'd4, 8'h44);
        expect_beat("t4_eth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t4_eth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t4_env", 64'h0144000401010000, 8'hff, 1'b0, 0);
        expect_beat("t4_pad", 64'h0, 8'hff, 1'b1, 0);
        rx_frame(FMAC, 8'd2, 8'h00, 16'h0001, 3);
        expect_beat("t4_deth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t4_deth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t4_dhdr", 64'h0144001003010000, 8'hff, 1'b0, 0);
        no_tx("t4_pay_wait");
        chk("t4_sready_pay", {63'd0, s_data_READY}, 64'd1);
        rx_frame(FMAC, 8'd2, 8'h00, 16'h0001, 2);
        s_data_VALID = 1'b1;
        s_data_DATA = 64'h7777;
        s_data_LAST = 1'b0;
        #1;
        chk("t4_pass_valid", {63'd0, stream_out_VALID}, 64'd1);
        aresetn = 1'b0;
        #1;
        chk("t4_rst_valid", {63'd0, stream_out_VALID}, 64'd0);
        chk("t4_rst_sready", {63'd0, s_data_READY}, 64'd0);
        chk("t4_rst_flags", {60'd0, req_ready, done, busy, error}, 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        s_data_VALID = 1'b0;
        send_req(MAC_A, 16'd0, 8'd1, 16'd2, 8'h55);
        expect_beat("t5_eth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t5_eth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t5_env", 64'h0155000201010000, 8'hff, 1'b0, 0);
        expect_beat("t5_pad", 64'h0, 8'hff, 1'b1, 0);
        rx_frame(FMAC, 8'd2, 8'h00, 16'h0001, 3);
        s_data_VALID = 1'b1;
        s_data_DATA = 64'h0102_0304_0506_0708;
        s_data_LAST = 1'b1;
        expect_beat("t5_deth0", 64'h16fa0f0e0d0c0b0a, 8'hff, 1'b0, 0);
        expect_beat("t5_deth1", 64'h0000007402ca553e, 8'hff, 1'b0, 0);
        expect_beat("t5_dhdr", 64'h0155000803010000, 8'hff, 1'b0, 0);
        expect_beat("t5_pay", 64'h0102_0304_0506_0708, 8'hff, 1'b1, 0);
        s_data_VALID = 1'b0;
        rx_frame(FMAC, 8'd4, 8'h00, 16'h0001, 3);
        chk("t5_done", {63'd0, done}, 64'd1);
        chk("t5_err", {63'd0, error}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
